umul_seq_ctrl: RTL and testbench

//  Sequencer for one replicated unary multiplier (rep_uMUL-style core with Sobol B path).

---
 rtl/umul_seq_ctrl_pkg.sv | 26 ++
 rtl/umul_seq_ctrl_unary_gen.sv | 68 ++++++
 rtl/umul_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_umul_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/umul_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// umul_seq_ctrl_pkg
//   Shared definitions for the unary-multiplier sequencer:
//     - state_e    : 2-bit FSM encoding (IDLE/LOAD/RUN/DONE)
//     - RUN_LEN    : cycles in one unary run for the default width
//     - run_len()  : the same quantity for any width
// ---------------------------------------------------------------------------
package umul_seq_ctrl_pkg;

    localparam int DEF_BITWIDTH = 8;

    // One run streams the full unary frame: 2^BITWIDTH cycles.
    localparam int RUN_LEN = 1 << DEF_BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int run_len(input int bw);
        return 1 << bw;
    endfunction

endpackage : umul_seq_ctrl_pkg

// File: rtl/umul_seq_ctrl_unary_gen.sv
// ---------------------------------------------------------------------------
// umul_unary_gen
//   Binary-to-unary converter for operand A. A BITWIDTH-bit cycle counter
//   walks 0..2^BITWIDTH-1 while i_run is high; the registered output bit is
//   high for the first A cycles of the run (o_core_a = A > cnt).
//
// Ports
//   iClk      in   1         clock, posedge
//   iRstN     in   1         synchronous active-low reset
//   i_start   in   1         LOAD cycle: preload counter 0 and first A bit
//   i_run     in   1         RUN cycle: advance counter
//   i_abort   in   1         drop the run, counter and A bit back to 0
//   i_a_val   in   BITWIDTH  registered operand A
//   o_core_a  out  1         unary A bit (registered)
//   o_last    out  1         current RUN cycle is the final one (cnt all ones)
//   o_cnt     out  BITWIDTH  current cycle index inside the run
// ---------------------------------------------------------------------------
module umul_unary_gen
    import umul_seq_ctrl_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                i_start,
    input  logic                i_run,
    input  logic                i_abort,
    input  logic [BITWIDTH-1:0] i_a_val,
    output logic                o_core_a,
    output logic                o_last,
    output logic [BITWIDTH-1:0] o_cnt
);

    localparam logic [BITWIDTH-1:0] LAST_CNT = BITWIDTH'(run_len(BITWIDTH) - 1);

    logic [BITWIDTH-1:0] r_cnt;
    logic                r_core_a;
    logic [BITWIDTH-1:0] w_cnt_next;
    logic                w_last;

    assign w_cnt_next = r_cnt + BITWIDTH'(1);
    assign w_last     = i_run && (r_cnt == LAST_CNT);

    // The A bit is computed one cycle ahead from the next count, so the
    // registered bit lines up with the count it belongs to (A > cnt).
    always_ff @(posedge iClk) begin
        if (!iRstN || i_abort) begin
            r_cnt    <= '0;
            r_core_a <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_core_a <= (i_a_val != '0);
        end else if (i_run) begin
            if (w_last) begin
                r_cnt    <= '0;
                r_core_a <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_next;
                r_core_a <= (i_a_val > w_cnt_next);
            end
        end
    end

    assign o_core_a = r_core_a;
    assign o_last   = w_last;
    assign o_cnt    = r_cnt;

endmodule : umul_unary_gen

// File: rtl/umul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// umul_seq_ctrl
//   Sequencer for one replicated unary multiplier core. Takes an (A,B) pair,
//   loads B into the core and clears its Sobol RNG (LOAD, 1 cycle), streams A
//   as a unary bitstream for 2^BITWIDTH cycles (RUN), counts the core's oMult
//   ones into a binary product and offers it to the consumer (DONE).
//
// Ports
//   iClk        in   1         clock, posedge
//   iRstN       in   1         synchronous active-low reset
//   iReqValid   in   1         operand pair valid
//   oReqReady   out  1         can accept operands (IDLE only)
//   iAVal       in   BITWIDTH  operand A (unary-coded here)
//   iBVal       in   BITWIDTH  operand B (forwarded to core)
//   oCoreA      out  1         unary A bit -> core iA
//   oCoreB      out  BITWIDTH  registered B -> core iB
//   oCoreLoadB  out  1         -> core loadB
//   oCoreClr    out  1         -> core iClr
//   iCoreMult   in   1         <- core oMult
//   oResValid   out  1         product valid
//   iResReady   in   1         consumer accepts product
//   oResult     out  BITWIDTH  product (count of oMult ones in one run)
//   oBusy       out  1         high in LOAD/RUN/DONE
//   oDbgState   out  state_e   current FSM state (debug)
//   iAbort      in   1         only with UMUL_SEQ_ABORT_EN: drop LOAD/RUN
//
// Build option: define UMUL_SEQ_ABORT_EN to add iAbort.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. The requester holds iAVal/iBVal stable while iReqValid is
// high; oResult stays stable while oResValid is high until the transfer.
// ---------------------------------------------------------------------------
module umul_seq_ctrl
    import umul_seq_ctrl_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iReqValid,
    output logic                oReqReady,
    input  logic [BITWIDTH-1:0] iAVal,
    input  logic [BITWIDTH-1:0] iBVal,
    output logic                oCoreA,
    output logic [BITWIDTH-1:0] oCoreB,
    output logic                oCoreLoadB,
    output logic                oCoreClr,
    input  logic                iCoreMult,
    output logic                oResValid,
    input  logic                iResReady,
    output logic [BITWIDTH-1:0] oResult,
    output logic                oBusy,
    output state_e              oDbgState
`ifdef UMUL_SEQ_ABORT_EN
    ,
    input  logic                iAbort
`endif
);

    state_e              r_state;
    logic [BITWIDTH-1:0] r_a;
    logic [BITWIDTH-1:0] r_b;
    logic                r_load_b;
    logic                r_clr;
    logic [BITWIDTH-1:0] r_acc;
    logic [BITWIDTH-1:0] r_result;
    logic                r_req_ready;
    logic                r_res_valid;
    logic                r_busy;

    logic                w_abort;
    logic                w_gen_abort;
    logic                w_start;
    logic                w_run;
    logic                w_last;
    logic                w_req_fire;
    logic [BITWIDTH-1:0] w_acc_sum;
    logic [BITWIDTH-1:0] w_cnt;

`ifdef UMUL_SEQ_ABORT_EN
    assign w_abort = iAbort;
`else
    assign w_abort = 1'b0;
`endif

    // Abort only matters while a run is being set up or streamed.
    assign w_gen_abort = w_abort && ((r_state == ST_LOAD) || (r_state == ST_RUN));
    assign w_start     = (r_state == ST_LOAD);
    assign w_run       = (r_state == ST_RUN);
    assign w_req_fire  = iReqValid && r_req_ready;

    // At most 2^BITWIDTH-1 ones per run (A ones in), so the sum cannot wrap.
    assign w_acc_sum = r_acc + BITWIDTH'(iCoreMult);

    umul_unary_gen #(
        .BITWIDTH (BITWIDTH)
    ) u_unary_gen (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .i_start  (w_start),
        .i_run    (w_run),
        .i_abort  (w_gen_abort),
        .i_a_val  (r_a),
        .o_core_a (oCoreA),
        .o_last   (w_last),
        .o_cnt    (w_cnt)
    );

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_load_b    <= 1'b0;
            r_clr       <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_a         <= iAVal;
                        r_b         <= iBVal;
                        r_load_b    <= 1'b1;
                        r_clr       <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    r_load_b <= 1'b0;
                    r_clr    <= 1'b0;
                    r_acc    <= '0;
                    if (w_abort) begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (w_abort) begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_acc <= w_acc_sum;
                        // The final cycle's oMult bit is folded straight into
                        // the product rather than waiting one more cycle.
                        if (w_last) begin
                            r_result    <= w_acc_sum;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (iResReady) begin
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_load_b    <= 1'b0;
                    r_clr       <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // The cycle index is carried for debug probing only.
    logic w_cnt_unused;
    assign w_cnt_unused = ^w_cnt;

    assign oReqReady  = r_req_ready;
    assign oCoreB     = r_b;
    assign oCoreLoadB = r_load_b;
    assign oCoreClr   = r_clr;
    assign oResValid  = r_res_valid;
    assign oResult    = r_result;
    assign oBusy      = r_busy;
    assign oDbgState  = r_state;

endmodule : umul_seq_ctrl

// File: tb/tb_umul_seq_ctrl.sv
// Bench for umul_seq_ctrl with a behavioural replicated unary multiplier core
// (B compared against a bit-reversed 8-bit Sobol sequence that advances on
// every iA=1 cycle and restarts on iClr).
module tb_umul_seq_ctrl;
  import umul_seq_ctrl_pkg::*;

  localparam int BW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT signals
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [BW-1:0] a_val = '0;
  logic [BW-1:0] b_val = '0;
  logic          core_a;
  logic [BW-1:0] core_b;
  logic          core_load_b;
  logic          core_clr;
  logic          core_mult;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [BW-1:0] result;
  logic          busy;
  state_e        dbg_state;
`ifdef UMUL_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  umul_seq_ctrl #(.BITWIDTH(BW)) dut (
    .iClk       (clk),
    .iRstN      (rst_n),
    .iReqValid  (req_valid),
    .oReqReady  (req_ready),
    .iAVal      (a_val),
    .iBVal      (b_val),
    .oCoreA     (core_a),
    .oCoreB     (core_b),
    .oCoreLoadB (core_load_b),
    .oCoreClr   (core_clr),
    .iCoreMult  (core_mult),
    .oResValid  (res_valid),
    .iResReady  (res_ready),
    .oResult    (result),
    .oBusy      (busy),
    .oDbgState  (dbg_state)
`ifdef UMUL_SEQ_ABORT_EN
    ,
    .iAbort     (abort)
`endif
  );

  // behavioural core
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  logic [7:0] m_b = '0;
  logic [7:0] m_idx = '0;
  assign core_mult = core_a & (m_b > bitrev8(m_idx));
  always @(posedge clk) begin
    if (core_load_b) m_b <= core_b;
    if (core_clr) m_idx <= '0;
    else if (core_a) m_idx <= m_idx + 8'd1;
  end

  // reference product: ones among the first A Sobol comparisons
  function automatic logic [7:0] ref_product(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < int'(a); i++) begin
      if (bitrev8(8'(i)) < b) n++;
    end
    return 8'(n);
  endfunction

  // scoreboard
  logic [BW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int   acc_edge = 0;
  int   ones_cnt = 0;
  logic [7:0] last_a = '0;
  logic prev_res_valid = 1'b0;
  logic [BW-1:0] exp_v;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && core_a) ones_cnt++;
      if (res_valid && !prev_res_valid) begin
        check("latency", 32'(cyc - acc_edge), 32'd257);
        check("a_ones", 32'(ones_cnt), 32'(last_a));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_res", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", 32'(result), 32'(exp_v));
        end
      end
    end
    prev_res_valid = res_valid;
  end

  // driver tasks
  task automatic send(input logic [7:0] a, input logic [7:0] b, output int waits);
    @(posedge clk); #1;
    a_val = a;
    b_val = b;
    req_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
      if (waits > 2000) begin
        check("req_timeout", 32'd1, 32'd0);
        break;
      end
    end
    exp_q.push_back(ref_product(a, b));
    acc_edge = cyc + 1;
    last_a = a;
    ones_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("load_b", 32'(core_load_b), 32'd1);
    check("clr", 32'(core_clr), 32'd1);
    check("core_a_load", 32'(core_a), 32'd0);
    check("ready_low", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        check("done_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seen;
    logic [7:0] ra, rb;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_a", 32'(core_a), 32'd0);
    check("rst_load_b", 32'(core_load_b), 32'd0);
    check("rst_clr", 32'(core_clr), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed pairs
    send(8'd128, 8'd128, w); wait_done();
    send(8'd128, 8'd64, w);  wait_done();
    send(8'd0, 8'd255, w);   wait_done();
    send(8'd255, 8'd0, w);   wait_done();
    send(8'd255, 8'd255, w); wait_done();
    check("done_idle", 32'(dbg_state), 32'(ST_IDLE));

    // random pairs
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, w);
      wait_done();
    end

    // back-to-back: second pair held valid while the first run is busy
    send(8'd100, 8'd200, w);
    send(8'd37, 8'd90, w);
    check("b2b_wait", 32'(w), 32'd257);
    wait_done();

    // consumer stall in DONE
    @(posedge clk); #1;
    res_ready = 1'b0;
    send(8'd200, 8'd100, w);
    seen = 0;
    while (!res_valid && seen < 400) begin
      @(negedge clk);
      seen++;
    end
    check("stall_reach_done", 32'(res_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_result", 32'(result), 32'(exp_q[0]));
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_done();

    // reset mid-run at cnt=100
    send(8'd128, 8'd128, w);
    repeat (101) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("cnt100_core_a", 32'(core_a), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_core_a", 32'(core_a), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    void'(exp_q.pop_back());
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);

`ifdef UMUL_SEQ_ABORT_EN
    // abort at cnt=50, then a normal run
    send(8'd128, 8'd128, w);
    repeat (51) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_core_a", 32'(core_a), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    void'(exp_q.pop_back());
    send(8'd128, 8'd128, w);
    wait_done();
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
